risc_controller: RTL and testbench

//   Eight-phase instruction sequencer for the VeriRISC core. Steps a 3-bit phase counter and

---
 rtl/risc_controller_pkg.sv | 27 ++
 rtl/risc_controller_phase_counter.sv | 27 ++
 rtl/risc_controller.sv | 98 +++++++++
 tb/tb_risc_controller.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/risc_controller_pkg.sv
// Shared constants for the VeriRISC controller: opcodes, phase encodings, bus widths.
package risc_controller_pkg;

  localparam int unsigned AWIDTH = 5;
  localparam int unsigned DWIDTH = 8;

  // Opcodes (instruction = {opcode, operand_addr})
  localparam logic [2:0] HLT = 3'd0;
  localparam logic [2:0] SKZ = 3'd1;
  localparam logic [2:0] ADD = 3'd2;
  localparam logic [2:0] AND = 3'd3;
  localparam logic [2:0] XOR = 3'd4;
  localparam logic [2:0] LDA = 3'd5;
  localparam logic [2:0] STO = 3'd6;
  localparam logic [2:0] JMP = 3'd7;

  // Phase encodings of the eight-phase instruction cycle
  localparam logic [2:0] INST_ADDR  = 3'd0;
  localparam logic [2:0] INST_FETCH = 3'd1;
  localparam logic [2:0] INST_LOAD  = 3'd2;
  localparam logic [2:0] IDLE       = 3'd3;
  localparam logic [2:0] OP_ADDR    = 3'd4;
  localparam logic [2:0] OP_FETCH   = 3'd5;
  localparam logic [2:0] ALU_OP     = 3'd6;
  localparam logic [2:0] STORE      = 3'd7;

endpackage

// File: rtl/risc_controller_phase_counter.sv
// Free-running phase counter with async active-low reset and count enable.
module risc_phase_counter #(
  parameter int unsigned PWIDTH = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_i,
  output logic [PWIDTH-1:0] count_o
);

  logic [PWIDTH-1:0] count_q, count_d;

  // Advance by one when enabled; natural wrap at 2**PWIDTH.
  always_comb begin
    count_d = count_q;
    if (en_i) count_d = count_q + PWIDTH'(1);
  end

  // Phase register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/risc_controller.sv
// VeriRISC eight-phase controller: steps the phase counter and decodes phase + opcode
// into memory, IR, PC, accumulator and bus-driver strobes. Halt is sticky until reset.
module risc_controller
  import risc_controller_pkg::*;
#(
  parameter int unsigned OWIDTH = 3,
  parameter int unsigned PWIDTH = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [OWIDTH-1:0] opcode,
  input  logic              zero,
  output logic              sel,
  output logic              rd,
  output logic              wr,
  output logic              ld_ir,
  output logic              inc_pc,
  output logic              ld_pc,
  output logic              ld_ac,
  output logic              data_e,
  output logic              halt,
  output logic [PWIDTH-1:0] phase
);

  logic              halt_q, halt_d;
  logic [PWIDTH-1:0] phase_q;
  logic              is_hlt, is_skz, is_sto, is_jmp, is_alu;
  logic              hlt_now;

  risc_phase_counter #(
    .PWIDTH (PWIDTH)
  ) u_phase_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (~halt_q),
    .count_o (phase_q)
  );

  // Opcode class flags used by the strobe decode.
  always_comb begin
    is_hlt  = (opcode == OWIDTH'(HLT));
    is_skz  = (opcode == OWIDTH'(SKZ));
    is_sto  = (opcode == OWIDTH'(STO));
    is_jmp  = (opcode == OWIDTH'(JMP));
    is_alu  = (opcode == OWIDTH'(ADD)) || (opcode == OWIDTH'(AND)) ||
              (opcode == OWIDTH'(XOR)) || (opcode == OWIDTH'(LDA));
    hlt_now = (phase_q == PWIDTH'(OP_ADDR)) && is_hlt;
  end

  // Halt latches on the OP_ADDR edge of an HLT instruction; only reset clears it.
  always_comb halt_d = halt_q | hlt_now;

  // Sticky halt register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) halt_q <= 1'b0;
    else        halt_q <= halt_d;
  end

  // Strobe decode per phase; everything is suppressed once halted.
  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    wr     = 1'b0;
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    ld_pc  = 1'b0;
    ld_ac  = 1'b0;
    data_e = 1'b0;
    if (!halt_q) begin
      case (phase_q)
        PWIDTH'(INST_ADDR):  sel = 1'b1;
        PWIDTH'(INST_FETCH): begin sel = 1'b1; rd = 1'b1; end
        PWIDTH'(INST_LOAD):  begin sel = 1'b1; rd = 1'b1; ld_ir = 1'b1; end
        PWIDTH'(IDLE):       begin sel = 1'b1; rd = 1'b1; ld_ir = 1'b1; end
        PWIDTH'(OP_ADDR):    inc_pc = 1'b1;
        PWIDTH'(OP_FETCH):   rd = is_alu;
        PWIDTH'(ALU_OP): begin
          rd     = is_alu;
          inc_pc = is_skz & zero;
          ld_pc  = is_jmp;
          data_e = is_sto;
        end
        PWIDTH'(STORE): begin
          rd     = is_alu;
          ld_ac  = is_alu;
          ld_pc  = is_jmp;
          wr     = is_sto;
          data_e = is_sto;
        end
        default: ;
      endcase
    end
    halt = halt_q | hlt_now;
  end

  assign phase = phase_q;

endmodule

// File: tb/tb_risc_controller.sv
// Self-checking bench for risc_controller: directed scenarios plus randomized
// opcode/zero/reset stimulus compared every cycle against a behavioural model.
module tb_risc_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       zero = 1'b0;
  logic [2:0] opcode = 3'd2;
  logic       sel, rd, wr, ld_ir, inc_pc, ld_pc, ld_ac, data_e, halt;
  logic [2:0] phase;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  int m_phase = 0;
  bit m_halt  = 0;

  // Tiny memory stand-in at operand address 0x0A
  logic [4:0] addr;
  logic [7:0] bus;
  logic [7:0] mem_a;

  risc_controller #(.OWIDTH(3), .PWIDTH(3)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero),
    .sel(sel), .rd(rd), .wr(wr), .ld_ir(ld_ir), .inc_pc(inc_pc),
    .ld_pc(ld_pc), .ld_ac(ld_ac), .data_e(data_e), .halt(halt), .phase(phase)
  );

  always #5 clk = ~clk;

  assign addr = sel ? 5'h00 : 5'h0A;
  assign bus  = data_e ? 8'hA5 : 8'hzz;
  always @(posedge clk) if (wr && addr == 5'h0A) mem_a <= bus;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Model: one phase per clock while running; HLT seen in phase 4 freezes at 5.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0;
      m_halt  = 0;
    end else if (!m_halt) begin
      if (m_phase == 4 && opcode == 3'd0) m_halt = 1;
      m_phase = (m_phase + 1) % 8;
    end
  end

  // Expected {sel,rd,wr,ld_ir,inc_pc,ld_pc,ld_ac,data_e,halt} from the opcode table.
  function automatic logic [8:0] model_out(input int ph, input bit hlt, input int op, input bit z);
    bit alu, sto, jmp, skz;
    logic [8:0] r;
    alu = (op >= 2 && op <= 5);
    sto = (op == 6);
    jmp = (op == 7);
    skz = (op == 1);
    if (hlt) return 9'b0_0000_0001;
    r[8] = (ph < 4);
    r[7] = (ph >= 1 && ph <= 3) || (ph >= 5 && alu);
    r[6] = (ph == 7) && sto;
    r[5] = (ph == 2 || ph == 3);
    r[4] = (ph == 4) || (ph == 6 && skz && z);
    r[3] = (ph >= 6) && jmp;
    r[2] = (ph == 7) && alu;
    r[1] = (ph >= 6) && sto;
    r[0] = (ph == 4) && (op == 0);
    return r;
  endfunction

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    logic [8:0] e, a;
    string nm [9];
    nm = '{"halt", "data_e", "ld_ac", "ld_pc", "inc_pc", "ld_ir", "wr", "rd", "sel"};
    e = model_out(m_phase, m_halt, int'(opcode), zero);
    a = {sel, rd, wr, ld_ir, inc_pc, ld_pc, ld_ac, data_e, halt};
    for (int unsigned i = 0; i < 9; i++) check({"cyc_", nm[i]}, 32'(a[i]), 32'(e[i]));
    check("cyc_phase", 32'(phase), 32'(m_phase));
  end

  // Advance to a negedge where the model sits in phase 0 (bounded).
  task automatic sync0();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (m_phase == 0) return;
    end
    check("sync0_timeout", 32'd1, 32'd0);
  endtask

  // Record one instruction's strobes, bit i = value in phase i.
  task automatic run_instr(output logic [7:0] rdv, output logic [7:0] incv, output logic [7:0] ldpcv);
    sync0();
    for (int i = 0; i < 8; i++) begin
      if (i > 0) begin @(negedge clk); #1; end
      rdv[i] = rd; incv[i] = inc_pc; ldpcv[i] = ld_pc;
    end
  endtask

  initial begin
    logic [7:0] rdv, incv, ldpcv;
    logic [7:0] rd_exp [9];
    rd_exp = '{8'd0, 8'd1, 8'd1, 8'd1, 8'd0, 8'd1, 8'd1, 8'd1, 8'd0};

    // 1: reset 3 cycles, ADD instruction walk
    #1 rst_n = 1'b0;
    check("reset_sel", 32'(sel), 32'd1);
    check("reset_phase", 32'(phase), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk); #2 rst_n = 1'b1; #1;
    for (int i = 0; i < 9; i++) begin
      if (i > 0) begin @(negedge clk); #1; end
      check("t1_phase", 32'(phase), 32'(i % 8));
      check("t1_rd", 32'(rd), 32'(rd_exp[i]));
      check("t1_ld_ac", 32'(ld_ac), 32'(i == 7));
      check("t1_wr", 32'(wr), 32'd0);
    end

    // 2: STO writes the accumulator at the operand address
    opcode = 3'd6;
    sync0();
    repeat (6) @(negedge clk); #1;
    check("t2_p6_data_e", 32'(data_e), 32'd1);
    check("t2_p6_wr", 32'(wr), 32'd0);
    @(negedge clk); #1;
    check("t2_p7_wr", 32'(wr), 32'd1);
    check("t2_p7_data_e", 32'(data_e), 32'd1);
    check("t2_p7_rd", 32'(rd), 32'd0);
    @(posedge clk); #1;
    check("t2_mem", 32'(mem_a), 32'hA5);

    // 3: SKZ with zero=1 and zero=0
    opcode = 3'd1; zero = 1'b1;
    run_instr(rdv, incv, ldpcv);
    check("t3_skz_z1_inc", 32'(incv), 32'h50);
    zero = 1'b0;
    run_instr(rdv, incv, ldpcv);
    check("t3_skz_z0_inc", 32'(incv), 32'h10);

    // 4: JMP
    opcode = 3'd7;
    run_instr(rdv, incv, ldpcv);
    check("t4_jmp_ld_pc", 32'(ldpcv), 32'hC0);
    check("t4_jmp_inc", 32'(incv), 32'h10);
    check("t4_jmp_rd", 32'(rdv), 32'h0E);

    // 5: HLT freezes at phase 5 until reset
    opcode = 3'd0;
    sync0();
    repeat (4) @(negedge clk); #1;
    check("t5_p4_phase", 32'(phase), 32'd4);
    check("t5_p4_halt", 32'(halt), 32'd1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      check("t5_frozen_phase", 32'(phase), 32'd5);
      check("t5_frozen_strobes", 32'({sel, rd, wr, ld_ir, inc_pc, ld_pc, ld_ac, data_e}), 32'd0);
      check("t5_frozen_halt", 32'(halt), 32'd1);
    end
    rst_n = 1'b0; #1;
    check("t5_rst_halt", 32'(halt), 32'd0);
    check("t5_rst_phase", 32'(phase), 32'd0);
    @(negedge clk); #2 rst_n = 1'b1;

    // 6: async reset in the middle of STO phase 6
    opcode = 3'd6;
    sync0();
    repeat (6) @(negedge clk); #1;
    check("t6_pre_data_e", 32'(data_e), 32'd1);
    #1 rst_n = 1'b0; #1;
    check("t6_wr", 32'(wr), 32'd0);
    check("t6_data_e", 32'(data_e), 32'd0);
    check("t6_phase", 32'(phase), 32'd0);
    check("t6_sel", 32'(sel), 32'd1);
    @(negedge clk); #2 rst_n = 1'b1;

    // Randomized: opcode changes outside IDLE..STORE, random zero, occasional resets
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk); #2;
      zero = 1'($urandom);
      if (m_phase <= 2 && $urandom_range(0, 2) == 0)
        opcode = ($urandom_range(0, 15) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
      if ((m_halt && $urandom_range(0, 5) == 0) || $urandom_range(0, 199) == 0) begin
        rst_n = 1'b0; #1;
        check("rnd_async_rst_phase", 32'(phase), 32'd0);
        rst_n = 1'b1;
      end
    end

    @(negedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
